// File: rtl/tca9539_i2c_master.sv
// Single-transaction I2C master issuing TCA9539 register writes and reads (1 or 2 data bytes).
// Optional build macro TCA9539_MASTER_NACK_ABORT_EN: slave NACK sets err and aborts to STOP.
module tca9539_i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rw,
    input  logic        two_bytes,
    input  logic [1:0]  dev_a,
    input  logic [2:0]  cmd,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        scl,
    inout  wire         sda
);
    localparam int            DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [6:0]    BASE_ADDR = 7'h74;

    typedef enum logic [3:0] {
        IDLE, START, SEND_BYTE, GET_ACK, RSTART, RECV_BYTE, SEND_ACK, STOP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rw_q, rw_d, two_q, two_d;
    logic [1:0]    dev_q, dev_d;
    logic [2:0]    cmd_q, cmd_d;
    logic [15:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic          err_q, err_d, done_q, done_d, busy_q, busy_d;
    logic          scl_q, scl_d, sda_oe_q, sda_oe_d;
    logic          sda_in, slot_end, sample_pt, last_byte, ack_fail;
    logic [1:0]    levels;

    // Byte sequence index: 0 addr+W, 1 cmd, then write data (2,3) or addr+R (2) and read data (3,4).
    function automatic logic [2:0] last_idx(input logic r, input logic two);
        return r ? (two ? 3'd4 : 3'd3) : (two ? 3'd3 : 3'd2);
    endfunction

    function automatic logic [7:0] byte_for(input logic [2:0] idx, input logic r,
                                            input logic [1:0] dev, input logic [2:0] c,
                                            input logic [15:0] w);
        logic [6:0] addr7;
        addr7 = BASE_ADDR | {5'b0, dev};
        case (idx)
            3'd0:    return {addr7, 1'b0};
            3'd1:    return {5'b0, c};
            3'd2:    return r ? {addr7, 1'b1} : w[7:0];
            default: return w[15:8];
        endcase
    endfunction

    // Returns {scl, sda_low} for a given slot state and quarter.
    function automatic logic [1:0] bus_levels(input state_t st, input logic [1:0] q,
                                              input logic tx_bit, input logic ack_low);
        case (st)
            START:               return {1'b1, q[1]};
            RSTART:              return {q != 2'd0, q[1]};
            SEND_BYTE:           return {q[1], ~tx_bit};
            GET_ACK, RECV_BYTE:  return {q[1], 1'b0};
            SEND_ACK:            return {q[1], ack_low};
            STOP:                return {q != 2'd0, ~q[1]};
            default:             return 2'b10;
        endcase
    endfunction

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in    = sda;
    assign slot_end  = (qtr_q == 2'd3) && (div_q == DIV_LAST);
    assign sample_pt = (qtr_q == 2'd3) && (div_q == '0);
    assign last_byte = (idx_q == last_idx(rw_q, two_q));

`ifdef TCA9539_MASTER_NACK_ABORT_EN
    logic nack_q, nack_d;

    always_comb begin
        nack_d = nack_q;
        if (state_q == GET_ACK && sample_pt) nack_d = sda_in;
    end

    always_ff @(posedge clk) begin
        if (reset) nack_q <= 1'b0;
        else       nack_q <= nack_d;
    end

    assign ack_fail = nack_q;
`else
    assign ack_fail = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        rw_d    = rw_q;
        two_d   = two_q;
        dev_d   = dev_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        if (state_q != IDLE && state_q != DONE) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else begin
                div_d = div_q + DW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    rw_d    = rw;
                    two_d   = two_bytes;
                    dev_d   = dev_a;
                    cmd_d   = cmd;
                    wdata_d = wdata;
                    err_d   = 1'b0;
                    div_d   = '0;
                    qtr_d   = 2'd0;
                    idx_d   = 3'd0;
                end
            end
            START: begin
                if (slot_end) begin
                    state_d = SEND_BYTE;
                    bit_d   = 3'd7;
                    shift_d = byte_for(3'd0, rw_q, dev_q, cmd_q, wdata_q);
                end
            end
            SEND_BYTE: begin
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = GET_ACK;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            GET_ACK: begin
                if (slot_end) begin
                    bit_d = 3'd7;
                    if (ack_fail) begin
                        state_d = STOP;
                        err_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = byte_for(idx_q + 3'd1, rw_q, dev_q, cmd_q, wdata_q);
                        if (last_byte)                    state_d = STOP;
                        else if (rw_q && idx_q == 3'd1)   state_d = RSTART;
                        else if (rw_q && idx_q >= 3'd2)   state_d = RECV_BYTE;
                        else                              state_d = SEND_BYTE;
                    end
                end
            end
            RSTART: begin
                if (slot_end) state_d = SEND_BYTE;
            end
            RECV_BYTE: begin
                if (sample_pt) shift_d[bit_q] = sda_in;
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = SEND_ACK;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            SEND_ACK: begin
                if (slot_end) begin
                    if (idx_q == 3'd3) rdata_d = {two_q ? rdata_q[15:8] : 8'h00, shift_q};
                    else               rdata_d[15:8] = shift_q;
                    if (last_byte) begin
                        state_d = STOP;
                    end else begin
                        state_d = RECV_BYTE;
                        idx_d   = idx_q + 3'd1;
                        bit_d   = 3'd7;
                    end
                end
            end
            STOP: begin
                if (slot_end) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus pins are registered from the next-state decode, so they never glitch.
        levels   = bus_levels(state_d, qtr_d, shift_d[bit_d], idx_d != last_idx(rw_d, two_d));
        scl_d    = levels[1];
        sda_oe_d = levels[0];
        done_d   = (state_d == DONE);
        busy_d   = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            qtr_q    <= 2'd0;
            bit_q    <= 3'd7;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            rw_q     <= 1'b0;
            two_q    <= 1'b0;
            dev_q    <= 2'd0;
            cmd_q    <= 3'd0;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            rw_q     <= rw_d;
            two_q    <= two_d;
            dev_q    <= dev_d;
            cmd_q    <= cmd_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign scl   = scl_q;
endmodule
